midi_trigger_tx: RTL and testbench

- Sits directly downstream of the 2-channel hard-coded step sequencer.
- Consumes its per-step trigger pulses (seqOut[1:0]) and turns each one into a MIDI Note On message.
- Sends a matching Note Off after a fixed gate time.
- Serializes all messages on a single 31250-baud MIDI UART line (8N1, LSB first) toward the DIN-out driver.

---
 rtl/midi_pkg.sv | 39 +++
 rtl/midi_uart_tx.sv | 95 +++++++++
 rtl/midi_trigger_tx.sv | 172 +++++++++++++++++
 tb/tb_midi_trigger_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI trigger transmitter: status nibbles,
// serializer state encoding, message selection record and width helpers.
package midi_pkg;

  // MIDI status nibbles (upper half of the status byte)
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] NOTE_OFF = 4'h8;

  // 50 MHz system clock / 31250 baud
  localparam int DEFAULT_CLKS_PER_BIT = 1600;

  // Index of the final byte of a 3-byte channel message
  localparam logic [1:0] LAST_BYTE = 2'd2;

  // Serializer line states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Which message the arbiter picked: Note On/Off and trigger channel
  typedef struct packed {
    logic is_off;
    logic ch;
  } msg_sel_t;

  // Status byte for a Note On/Off on the given channel nibble
  function automatic logic [7:0] status_byte(input logic is_off, input logic [3:0] ch);
    return {(is_off ? NOTE_OFF : NOTE_ON), ch};
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// 8N1 byte serializer, LSB first, idle high. A byte is accepted on load
// while ready is high; ready is also raised during the final clock of a
// stop bit so consecutive bytes go out with no idle time between them.
module midi_uart_tx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int BW = cnt_width(CLKS_PER_BIT);

  tx_state_e     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign ready   = (state == IDLE) || ((state == STOP) && bit_end);

  // Line state machine: start bit, eight data bits, stop bit, then either the next byte or idle
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      case (state)
        IDLE: begin
          if (load) begin
            state    <= START;
            tx       <= 1'b0;
            shreg    <= data;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            tx       <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            bit_idx  <= '0;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (load) begin
              state <= START;
              tx    <= 1'b0;
              shreg <= data;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/midi_trigger_tx.sv
// Turns two-channel sequencer trigger pulses into MIDI Note On messages,
// schedules a Note Off after a fixed gate time, and serializes everything
// on a single MIDI UART line.
module midi_trigger_tx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int MIDI_CH      = 9,
  parameter int NOTE0        = 36,
  parameter int NOTE1        = 38,
  parameter int VELOCITY     = 100,
  parameter int GATE_CLKS    = 2500000
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [1:0] seqIn,
  output logic       midiTx,
  output logic       busy,
  output logic       overrun
);

  localparam int GW = cnt_width(GATE_CLKS + 1);

  logic [1:0]    on_pend;
  logic [1:0]    off_pend;
  logic [GW-1:0] gate [2];

  logic          msg_active;
  msg_sel_t      msg;
  logic [1:0]    byte_idx;

  logic          uart_ready;
  logic          uart_load;
  logic [7:0]    uart_data;

  msg_sel_t      sel;
  logic          sel_valid;
  logic          last_done;
  logic          sel_en;
  logic          start;
  logic          next_byte;
  logic [1:0]    consume_on;
  logic [1:0]    consume_off;
  logic [1:0]    reload;
  logic [1:0]    retrig;
  logic [1:0]    expire;

  // Byte idx of message m: status, note number, velocity (zero for Note Off)
  function automatic logic [7:0] msg_byte(input msg_sel_t m, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = status_byte(m.is_off, 4'(MIDI_CH));
      2'd1:    b = m.ch ? {1'b0, 7'(NOTE1)} : {1'b0, 7'(NOTE0)};
      default: b = m.is_off ? 8'h00 : {1'b0, 7'(VELOCITY)};
    endcase
    return b;
  endfunction

  // Fixed-priority arbiter: pending Note Offs first, then Note Ons, lower channel first
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a value held (no latch).
    sel_valid  = 1'b1;
    sel.is_off = 1'b0;
    sel.ch     = 1'b0;
    if (off_pend[0]) begin
      sel.is_off = 1'b1;
    end else if (off_pend[1]) begin
      sel.is_off = 1'b1;
      sel.ch     = 1'b1;
    end else if (on_pend[0]) begin
      sel.ch     = 1'b0;
    end else if (on_pend[1]) begin
      sel.ch     = 1'b1;
    end else begin
      sel_valid  = 1'b0;
    end
  end

  // Message sequencing decode: a new message may start when idle or as the previous one's last stop bit ends
  always_comb begin
    last_done = msg_active && uart_ready && (byte_idx == LAST_BYTE);
    sel_en    = !msg_active || last_done;
    start     = sel_en && sel_valid;
    next_byte = msg_active && uart_ready && (byte_idx != LAST_BYTE);
    uart_load = start || next_byte;
    uart_data = start ? msg_byte(sel, 2'd0) : msg_byte(msg, byte_idx + 2'd1);
    for (int i = 0; i < 2; i++) begin
      consume_on[i]  = start && !sel.is_off && (sel.ch == 1'(i));
      consume_off[i] = start &&  sel.is_off && (sel.ch == 1'(i));
      reload[i]      = last_done && !msg.is_off && (msg.ch == 1'(i));
      // A gate that is running, or is about to be armed by the Note On just finishing,
      // forces a Note Off before this new Note On's own gate starts.
      retrig[i]      = consume_on[i] && ((gate[i] != '0) || reload[i]);
      expire[i]      = (gate[i] == GW'(1));
    end
  end

  // Trigger capture, overrun detection and Note Off request flags
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      on_pend  <= '0;
      off_pend <= '0;
      overrun  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (seqIn[i]) begin
          if (on_pend[i] && !consume_on[i]) begin
            overrun <= 1'b1;
          end else begin
            on_pend[i] <= 1'b1;
          end
        end else if (consume_on[i]) begin
          on_pend[i] <= 1'b0;
        end
        if (expire[i] || retrig[i]) begin
          off_pend[i] <= 1'b1;
        end else if (consume_off[i]) begin
          off_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Per-channel gate timers: armed when a Note On finishes, cleared on retrigger, count down to zero
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      gate[0] <= '0;
      gate[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (retrig[i]) begin
          gate[i] <= '0;
        end else if (reload[i]) begin
          gate[i] <= GW'(GATE_CLKS);
        end else if (gate[i] != '0) begin
          gate[i] <= gate[i] - 1'b1;
        end
      end
    end
  end

  // Current message record and byte position within it
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      msg_active <= 1'b0;
      msg        <= '0;
      byte_idx   <= '0;
    end else if (start) begin
      msg_active <= 1'b1;
      msg        <= sel;
      byte_idx   <= '0;
    end else if (last_done) begin
      msg_active <= 1'b0;
    end else if (next_byte) begin
      byte_idx   <= byte_idx + 2'd1;
    end
  end

  assign busy = msg_active;

  midi_uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clock (clock),
    .clear (clear),
    .load  (uart_load),
    .data  (uart_data),
    .ready (uart_ready),
    .tx    (midiTx)
  );

endmodule

// File: tb/tb_midi_trigger_tx.sv
// Directed bench for midi_trigger_tx with CLKS_PER_BIT=4, GATE_CLKS=100.
// A line decoder records every received byte with the cycle its start bit
// began; each scenario compares that stream against hand-built messages.
module tb_midi_trigger_tx;

  localparam int CPB  = 4;
  localparam int BYTE = 10 * CPB;
  localparam int MSG  = 3 * BYTE;

  logic       clock;
  logic       clear;
  logic [1:0] seqIn;
  logic       midiTx;
  logic       busy;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic       mon_en;
  logic       rx_busy = 1'b0;
  int         rx_cnt  = 0;
  int         rx_t    = 0;
  logic [7:0] rx_sh   = '0;
  int         frame_errs = 0;

  logic [7:0] rx_q[$];
  int         rx_tq[$];
  logic [7:0] exp_q[$];
  int         exp_tq[$];

  int t0;
  int s;
  int lows;
  int highs;

  midi_trigger_tx #(
    .CLKS_PER_BIT (CPB),
    .MIDI_CH      (9),
    .NOTE0        (36),
    .NOTE1        (38),
    .VELOCITY     (100),
    .GATE_CLKS    (100)
  ) dut (
    .clock   (clock),
    .clear   (clear),
    .seqIn   (seqIn),
    .midiTx  (midiTx),
    .busy    (busy),
    .overrun (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Line decoder sampling mid-bit on falling clock edges
  always @(negedge clock) begin
    if (!mon_en || clear) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (midiTx === 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 0;
        rx_t    <= cyc;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (((rx_cnt + 1) % CPB) == (CPB / 2)) begin
        case ((rx_cnt + 1) / CPB)
          0: if (midiTx !== 1'b0) frame_errs <= frame_errs + 1;
          9: begin
            if (midiTx !== 1'b1) frame_errs <= frame_errs + 1;
            rx_q.push_back(rx_sh);
            rx_tq.push_back(rx_t);
            rx_busy <= 1'b0;
          end
          default: rx_sh <= {midiTx, rx_sh[7:1]};
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_msg(input bit off, input bit ch, input int t);
    exp_q.push_back(off ? 8'h89 : 8'h99);
    exp_q.push_back(ch ? 8'h26 : 8'h24);
    exp_q.push_back(off ? 8'h00 : 8'h64);
    for (int k = 0; k < 3; k++) exp_tq.push_back(t + BYTE * k);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while ((rx_q.size() < n) && (b > 0)) begin
      @(negedge clock);
      b--;
    end
    check({tag, "_timeout"}, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) begin
        check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        check($sformatf("%s_time%0d", tag, i), 32'(rx_tq[i]), 32'(exp_tq[i]));
      end
    end
    rx_q.delete();
    rx_tq.delete();
    exp_q.delete();
    exp_tq.delete();
  endtask

  // One-cycle pulse; t is the cycle number right after the sampling edge
  task automatic pulse(input logic [1:0] v, output int t);
    @(negedge clock);
    seqIn = v;
    @(posedge clock);
    #1 t = cyc;
    @(negedge clock);
    seqIn = 2'b00;
  endtask

  task automatic wait_until_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear  = 1'b0;
    seqIn  = 2'b00;
    mon_en = 1'b0;
    #1 clear = 1'b1;
    #20;
    check("rst_midiTx",  32'(midiTx),  32'd1);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clock);
    clear = 1'b0;

    // 1: clear lands mid start bit while channel 1 is still pending
    pulse(2'b11, t0);
    wait_until_cyc(t0 + 2);
    check("t1_start_low", 32'(midiTx), 32'd0);
    check("t1_busy_on",   32'(busy),   32'd1);
    #2 clear = 1'b1;
    #1;
    check("t1_clr_midiTx",  32'(midiTx),  32'd1);
    check("t1_clr_busy",    32'(busy),    32'd0);
    check("t1_clr_overrun", 32'(overrun), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    lows  = 0;
    highs = 0;
    repeat (1000) begin
      @(negedge clock);
      if (midiTx !== 1'b1) lows++;
      if (busy !== 1'b0) highs++;
    end
    check("t1_idle_low_cycles",  32'(lows),  32'd0);
    check("t1_idle_busy_cycles", 32'(highs), 32'd0);

    // 2: single channel-0 trigger, Note Off after the gate
    mon_en = 1'b1;
    pulse(2'b01, t0);
    s = t0 + 1;
    push_msg(1'b0, 1'b0, s);
    push_msg(1'b1, 1'b0, s + MSG + 101);
    wait_bytes("t2", 6, 800);
    repeat (300) @(negedge clock);
    compare_stream("t2");

    // 3: both channels on one edge
    pulse(2'b11, t0);
    s = t0 + 1;
    push_msg(1'b0, 1'b0, s);
    push_msg(1'b0, 1'b1, s + MSG);
    push_msg(1'b1, 1'b0, s + 2 * MSG);
    push_msg(1'b1, 1'b1, s + 3 * MSG);
    wait_bytes("t3", 12, 1000);
    repeat (300) @(negedge clock);
    compare_stream("t3");

    // 4: retrigger channel 0 fifty clocks into its gate
    pulse(2'b01, t0);
    s = t0 + 1;
    wait_until_cyc(s + MSG + 49);
    seqIn = 2'b01;
    @(negedge clock);
    seqIn = 2'b00;
    push_msg(1'b0, 1'b0, s);
    push_msg(1'b0, 1'b0, s + MSG + 51);
    push_msg(1'b1, 1'b0, s + 2 * MSG + 51);
    push_msg(1'b1, 1'b0, s + 3 * MSG + 51);
    wait_bytes("t4", 12, 1000);
    repeat (300) @(negedge clock);
    compare_stream("t4");

    // 5: two channel-1 pulses while channel 0 is on the wire
    pulse(2'b01, t0);
    s = t0 + 1;
    wait_until_cyc(s + 9);
    seqIn = 2'b10;
    @(negedge clock);
    seqIn = 2'b00;
    check("t5_overrun_first", 32'(overrun), 32'd0);
    wait_until_cyc(s + 19);
    seqIn = 2'b10;
    @(negedge clock);
    seqIn = 2'b00;
    check("t5_overrun_second", 32'(overrun), 32'd1);
    push_msg(1'b0, 1'b0, s);
    push_msg(1'b0, 1'b1, s + MSG);
    push_msg(1'b1, 1'b0, s + 2 * MSG);
    push_msg(1'b1, 1'b1, s + 3 * MSG);
    wait_bytes("t5", 12, 1000);
    repeat (300) @(negedge clock);
    compare_stream("t5");
    check("t5_overrun_sticky", 32'(overrun), 32'd1);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("t5_overrun_cleared", 32'(overrun), 32'd0);

    // 6: second pulse on the edge that consumes the first
    @(negedge clock);
    seqIn = 2'b01;
    @(posedge clock);
    #1 t0 = cyc;
    @(negedge clock);
    @(negedge clock);
    seqIn = 2'b00;
    s = t0 + 1;
    push_msg(1'b0, 1'b0, s);
    push_msg(1'b0, 1'b0, s + MSG);
    push_msg(1'b1, 1'b0, s + 2 * MSG);
    push_msg(1'b1, 1'b0, s + 3 * MSG);
    wait_bytes("t6", 12, 1000);
    repeat (300) @(negedge clock);
    compare_stream("t6");
    check("t6_overrun", 32'(overrun), 32'd0);

    check("framing_errors", 32'(frame_errs), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
